// File: rtl/ram_pkg.sv
// Shared widths and types for the dual-port RAM and its port initiators.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 3;
  localparam int RAM_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} ram_master_state_t;

  typedef struct packed {
    logic                      wr;
    logic [RAM_ADDR_WIDTH-1:0] addr;
    logic [RAM_LEN_WIDTH-1:0]  len;
  } ram_cmd_t;

endpackage

// File: rtl/ram_rd_capture.sv
// Read-data capture for one RAM port: pending flag for the 1-cycle RAM latency
// plus a single output register presented as a valid/ready stream.
module ram_rd_capture
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  rdata_ready,
  output logic                  pending,
  output logic                  capture,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata
);

  // A pending word can move into the output register when it is empty or
  // being drained this cycle; mem_dout holds until the next read is issued.
  assign capture = pending && (!rdata_valid || rdata_ready);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending     <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      if (issue) begin
        pending <= 1'b1;
      end else if (capture) begin
        pending <= 1'b0;
      end
      if (capture) begin
        rdata       <= mem_dout;
        rdata_valid <= 1'b1;
      end else if (rdata_ready) begin
        rdata_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_port_master.sv
// Burst initiator for one port of the dual-port RAM. Optional saturating beat
// counters are built when RAM_PORT_MASTER_STATS_EN is defined.
module ram_port_master
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_chipe,
  output logic                  mem_wre,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output ram_master_state_t     fsm_state
`ifdef RAM_PORT_MASTER_STATS_EN
  ,
  output logic [15:0]           stat_wr_beats,
  output logic [15:0]           stat_rd_beats
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, ready may depend on valid.

  ram_master_state_t     state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  pending;
  logic                  capture;
  logic                  issue;
  logic                  wr_beat;

  assign wr_beat = (state == WRITE) && wdata_valid;
  assign issue   = (state == READ) && (!pending || capture);

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign wdata_ready = (state == WRITE);
  assign fsm_state   = state;

  assign mem_chipe = wr_beat || issue;
  assign mem_wre   = wr_beat;
  assign mem_addr  = addr;
  assign mem_din   = wdata;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == '0) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last read is pending here; leave once it reaches the output register.
          if (capture) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_rd_capture #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_capture (
    .clk        (clk),
    .nrst       (nrst),
    .issue      (issue),
    .mem_dout   (mem_dout),
    .rdata_ready(rdata_ready),
    .pending    (pending),
    .capture    (capture),
    .rdata_valid(rdata_valid),
    .rdata      (rdata)
  );

`ifdef RAM_PORT_MASTER_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_wr_beats <= '0;
      stat_rd_beats <= '0;
    end else begin
      if (wr_beat && (stat_wr_beats != 16'hFFFF)) begin
        stat_wr_beats <= stat_wr_beats + 16'd1;
      end
      if (capture && (stat_rd_beats != 16'hFFFF)) begin
        stat_rd_beats <= stat_rd_beats + 16'd1;
      end
    end
  end
`endif

endmodule
